// File: rtl/skid_buffer.sv
// Two-entry skid buffer: registered head (main) plus an overflow register (skid).
// Optional flush/stall statistics counters are built when SKID_BUFFER_STATS_EN is defined.
module skid_buffer #(
  parameter int N = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         hold,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   occupancy
`ifdef SKID_BUFFER_STATS_EN
  ,
  output logic [15:0]  stall_count,
  output logic [15:0]  drop_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic [N-1:0] main_p0, main_nxt;
  logic [N-1:0] skid_p0, skid_nxt;
  logic         in_xfer, out_xfer;

  // Handshakes are masked by hold/flush so neither side can see a transfer
  // while the buffer is frozen or being emptied.
  assign in_ready  = (state != FULL)  && !hold && !flush;
  assign out_valid = (state != EMPTY) && !hold && !flush;
  assign out_data  = main_p0;
  assign occupancy = state;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    main_nxt  = main_p0;
    skid_nxt  = skid_p0;
    if (flush) begin
      state_nxt = EMPTY;
      main_nxt  = '0;
      skid_nxt  = '0;
    end else if (!hold) begin
      unique case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_nxt  = in_data;
            state_nxt = ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_nxt = in_data;
          end else if (in_xfer) begin
            skid_nxt  = in_data;
            state_nxt = FULL;
          end else if (out_xfer) begin
            main_nxt  = '0;
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain path exists.
          if (out_xfer) begin
            main_nxt  = skid_p0;
            skid_nxt  = '0;
            state_nxt = ONE;
          end
        end
        default: begin
          state_nxt = EMPTY;
          main_nxt  = '0;
          skid_nxt  = '0;
        end
      endcase
    end
  end

  // Stage p0: buffer registers; reset clears data too so empty slots read 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= EMPTY;
      main_p0 <= '0;
      skid_p0 <= '0;
    end else begin
      state   <= state_nxt;
      main_p0 <= main_nxt;
      skid_p0 <= skid_nxt;
    end
  end

`ifdef SKID_BUFFER_STATS_EN
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // Stage p0: statistics; drops count whatever the flush discards.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
      drop_count  <= '0;
    end else begin
      if (in_valid && !in_ready)
        stall_count <= sat_add16(stall_count, 16'd1);
      if (flush)
        drop_count <= sat_add16(drop_count, {14'd0, occupancy});
    end
  end
`endif

endmodule

// File: tb/tb_skid_buffer.sv
// Self-checking bench for skid_buffer: vector table, hand sequences, and a
// scoreboarded random stream. Counter checks appear when SKID_BUFFER_STATS_EN is defined.
module tb_skid_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush, hold, in_valid, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
`ifdef SKID_BUFFER_STATS_EN
  logic [15:0] stall_count, drop_count;
`endif

  skid_buffer #(.N(32)) dut (
    .clock(clock), .reset(reset), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy)
`ifdef SKID_BUFFER_STATS_EN
    , .stall_count(stall_count), .drop_count(drop_count)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        fl, hd, iv;
    logic [31:0] d;
    logic        ordy;
    logic        ov;
    logic [31:0] od;
    logic [1:0]  occ;
    logic        ir;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(logic fl, logic hd, logic iv, logic [31:0] d, logic ordy,
                              logic ov, logic [31:0] od, logic [1:0] occ, logic ir);
    vec_t v;
    v.fl = fl; v.hd = hd; v.iv = iv; v.d = d; v.ordy = ordy;
    v.ov = ov; v.od = od; v.occ = occ; v.ir = ir;
    return v;
  endfunction

  int q[$];

  initial begin
    int exp_stall, exp_drop, sent, recv, cyc, exp_v;

    // Expected outputs are those seen before the edge that applies the row's inputs.
    //              fl hd iv data           or   ov od            occ ir
    vecs[0]  = mk(0, 0, 0, 32'h0,        0,   0, 32'h0,        0, 1);
    vecs[1]  = mk(0, 0, 1, 32'hA5A5A5A5, 1,   0, 32'h0,        0, 1);
    vecs[2]  = mk(0, 0, 0, 32'h0,        0,   1, 32'hA5A5A5A5, 1, 1);
    vecs[3]  = mk(0, 0, 0, 32'h0,        1,   1, 32'hA5A5A5A5, 1, 1);
    vecs[4]  = mk(0, 0, 1, 32'h1,        0,   0, 32'h0,        0, 1);
    vecs[5]  = mk(0, 0, 1, 32'h2,        0,   1, 32'h1,        1, 1);
    vecs[6]  = mk(0, 0, 1, 32'h3,        0,   1, 32'h1,        2, 0);
    vecs[7]  = mk(0, 0, 0, 32'h0,        1,   1, 32'h1,        2, 0);
    vecs[8]  = mk(0, 0, 0, 32'h0,        1,   1, 32'h2,        1, 1);
    vecs[9]  = mk(0, 0, 0, 32'h0,        1,   0, 32'h0,        0, 1);
    vecs[10] = mk(0, 0, 1, 32'h7,        0,   0, 32'h0,        0, 1);
    vecs[11] = mk(0, 1, 1, 32'h8,        1,   0, 32'h7,        1, 0);
    vecs[12] = mk(0, 1, 1, 32'h8,        1,   0, 32'h7,        1, 0);
    vecs[13] = mk(0, 1, 1, 32'h8,        1,   0, 32'h7,        1, 0);
    vecs[14] = mk(0, 0, 1, 32'h8,        1,   1, 32'h7,        1, 1);
    vecs[15] = mk(0, 0, 0, 32'h0,        1,   1, 32'h8,        1, 1);
    vecs[16] = mk(0, 0, 1, 32'h9,        0,   0, 32'h0,        0, 1);
    vecs[17] = mk(0, 0, 1, 32'hA,        0,   1, 32'h9,        1, 1);
    vecs[18] = mk(1, 0, 1, 32'hB,        1,   0, 32'h9,        2, 0);
    vecs[19] = mk(0, 0, 0, 32'h0,        0,   0, 32'h0,        0, 1);
    vecs[20] = mk(0, 0, 1, 32'h5,        0,   0, 32'h0,        0, 1);
    vecs[21] = mk(1, 1, 0, 32'h0,        1,   0, 32'h5,        1, 0);
    vecs[22] = mk(0, 0, 0, 32'h0,        1,   0, 32'h0,        0, 1);

    reset = 1'b0; flush = 0; hold = 0; in_valid = 0; out_ready = 0; in_data = '0;
    repeat (3) @(negedge clock);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_in_ready", in_ready, 1);
    reset = 1'b1;

    exp_stall = 0; exp_drop = 0;
    for (int i = 0; i < 23; i++) begin
      @(negedge clock);
      flush = vecs[i].fl; hold = vecs[i].hd; in_valid = vecs[i].iv;
      in_data = vecs[i].d; out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].ov);
      chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].od);
      chk($sformatf("vec%0d_occ", i), occupancy, vecs[i].occ);
      chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].ir);
      if (vecs[i].iv && !vecs[i].ir) exp_stall++;
      if (vecs[i].fl) exp_drop += vecs[i].occ;
    end
    @(negedge clock);
    flush = 0; hold = 0; in_valid = 0; out_ready = 0;
    #1;
`ifdef SKID_BUFFER_STATS_EN
    chk("stall_count", stall_count, exp_stall);
    chk("drop_count", drop_count, exp_drop);
`endif

    // Back-to-back throughput with out_ready held high.
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      in_valid = 1; in_data = 100 + i; out_ready = 1;
      #1;
      chk($sformatf("tput%0d_in_ready", i), in_ready, 1);
      if (i > 0) begin
        chk($sformatf("tput%0d_out_valid", i), out_valid, 1);
        chk($sformatf("tput%0d_out_data", i), out_data, 100 + i - 1);
      end
    end
    @(negedge clock);
    in_valid = 0;
    #1;
    chk("tput_last_data", out_data, 105);
    @(negedge clock);
    #1;
    chk("tput_drained", occupancy, 0);

    // Fill to FULL, then assert reset asynchronously with a pop pending.
    in_valid = 1; out_ready = 0; in_data = 32'h1;
    @(negedge clock); in_data = 32'h2;
    @(negedge clock); in_data = 32'h3;
    #1;
    chk("pre_arst_occ", occupancy, 2);
    out_ready = 1;
    #2 reset = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_occ", occupancy, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_in_ready", in_ready, 1);
    @(posedge clock); #1;
    chk("arst_edge_occ", occupancy, 0);
    @(negedge clock);
    in_valid = 0; reset = 1'b1;
    #1;
    chk("arst_rel_occ", occupancy, 0);
    chk("arst_rel_valid", out_valid, 0);
`ifdef SKID_BUFFER_STATS_EN
    chk("arst_stall_count", stall_count, 0);
    chk("arst_drop_count", drop_count, 0);
`endif

    // Random stream scored against a FIFO queue.
    sent = 0; recv = 0; cyc = 0;
    while (recv < 1000 && cyc < 20000) begin
      @(negedge clock);
      cyc++;
      in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      in_data   = sent;
      out_ready = ($urandom_range(0, 3) != 0);
      hold      = ($urandom_range(0, 15) == 0);
      #1;
      if (in_valid && in_ready) begin
        q.push_back(sent);
        sent++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rand_unexpected_output", out_data, 32'hFFFFFFFF);
        end else begin
          exp_v = q.pop_front();
          chk($sformatf("rand_item%0d", recv), out_data, exp_v);
        end
        recv++;
      end
    end
    chk("rand_received", recv, 1000);
    chk("rand_queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
